// File: rtl/a2d_rr_sched.sv
`default_nettype none
// a2d_rr_sched -- round-robin scheduler for four A2D channels; each conversion
// issues the same SPI command twice and keeps only the second reply. (rev 1.0)
module a2d_rr_sched #(
   parameter int TIMEOUT   = 1024,
   parameter int PAUSE_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        vld,
   output logic [1:0]  vld_idx,
   output logic        busy,
   output logic        err
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int PC_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAUSE_CYC - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TX1   = 3'd1,
      WAIT1 = 3'd2,
      PAUSE = 3'd3,
      TX2   = 3'd4,
      WAIT2 = 3'd5
   } state_t;

   state_t            state_q;
   logic [1:0]        ptr_q;
   logic [1:0]        ptr_d;
   logic              pend_q;
   logic [WD_W-1:0]   wd_q;
   logic [PC_W-1:0]   pc_q;
   logic              err_q;
   logic              spi_wrt_q;
   logic              vld_q;
   logic [1:0]        vld_idx_q;
   logic [11:0]       ch_q [4];
   logic [2:0]        chan;
   logic              wd_expired;
   logic              unused_rd_hi;

   assign ptr_d        = ptr_q + 2'd1;
   assign wd_expired   = (wd_q == WD_LAST);
   assign unused_rd_hi = ^spi_rd[15:12];

   // Pointer only moves when a conversion ends, so the command is stable
   // across both transactions without a separate holding register.
   always_comb begin
      chan = 3'd0;
      case (ptr_q)
         2'd0:    chan = 3'd0;
         2'd1:    chan = 3'd4;
         2'd2:    chan = 3'd5;
         default: chan = 3'd6;
      endcase
   end

   assign spi_cmd   = {2'b00, chan, 11'h000};
   assign spi_wrt   = spi_wrt_q;
   assign vld       = vld_q;
   assign vld_idx   = vld_idx_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign lft_ld    = ch_q[0];
   assign rght_ld   = ch_q[1];
   assign steer_pot = ch_q[2];
   assign batt      = ch_q[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         pend_q    <= 1'b0;
         wd_q      <= '0;
         pc_q      <= '0;
         err_q     <= 1'b0;
         spi_wrt_q <= 1'b0;
         vld_q     <= 1'b0;
         vld_idx_q <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            ch_q[i] <= 12'h000;
         end
      end else begin
         spi_wrt_q <= 1'b0;
         vld_q     <= 1'b0;
         if (nxt && (state_q != IDLE)) begin
            pend_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (nxt || pend_q) begin
                  state_q   <= TX1;
                  spi_wrt_q <= 1'b1;
                  pend_q    <= 1'b0;
               end
            end
            TX1: begin
               state_q <= WAIT1;
               wd_q    <= '0;
            end
            WAIT1: begin
               // First reply is stale data from the previous command.
               if (spi_done) begin
                  state_q <= PAUSE;
                  pc_q    <= '0;
               end else if (wd_expired) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  ptr_q   <= ptr_d;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            PAUSE: begin
               if (pc_q == PC_LAST) begin
                  state_q   <= TX2;
                  spi_wrt_q <= 1'b1;
               end else begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            TX2: begin
               state_q <= WAIT2;
               wd_q    <= '0;
            end
            WAIT2: begin
               if (spi_done) begin
                  ch_q[ptr_q] <= spi_rd[11:0];
                  vld_q       <= 1'b1;
                  vld_idx_q   <= ptr_q;
                  ptr_q       <= ptr_d;
                  state_q     <= IDLE;
               end else if (wd_expired) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  ptr_q   <= ptr_d;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_sched.sv
`default_nettype none
// tb_a2d_rr_sched -- directed self-checking bench for a2d_rr_sched. (rev 1.0)
module tb_a2d_rr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nxt = 1'b0;
   logic        spi_done = 1'b0;
   logic [15:0] spi_rd = 16'h0000;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic        vld, busy, err;
   logic [1:0]  vld_idx;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   a2d_rr_sched #(.TIMEOUT(16), .PAUSE_CYC(1)) dut (
      .clk(clk), .rst(rst), .nxt(nxt),
      .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
      .spi_done(spi_done), .spi_rd(spi_rd),
      .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
      .vld(vld), .vld_idx(vld_idx), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1);
   end

   // After step() the bench sits 1 ns into a new cycle: outputs show that
   // cycle's values and inputs set now are sampled at the end of it.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; nxt = 1'b0; spi_done = 1'b0; spi_rd = 16'h0000;
      repeat (3) step();
      rst = 1'b0;
   endtask

   task automatic pulse_nxt();
      nxt = 1'b1;
      step();
      nxt = 1'b0;
   endtask

   task automatic wait_wrt(output int t, output bit found);
      found = 1'b0;
      t = -1;
      for (int i = 0; i < 40 && !found; i++) begin
         if (spi_wrt) begin
            found = 1'b1;
            t = cyc;
         end else begin
            step();
         end
      end
   endtask

   // Called in a wrt cycle; spi_done is driven in cycle wrt+gap.
   task automatic finish_txn(input int gap, input logic [15:0] rd);
      repeat (gap) step();
      spi_done = 1'b1;
      spi_rd   = rd;
      step();
      spi_done = 1'b0;
      spi_rd   = 16'h0000;
   endtask

   task automatic do_conv(input logic [15:0] rd, output int t1, output int t2,
                          output logic [15:0] c1, output logic [15:0] c2, output bit ok);
      bit f1, f2;
      wait_wrt(t1, f1);
      c1 = spi_cmd;
      finish_txn(9, 16'h0BAD);
      wait_wrt(t2, f2);
      c2 = spi_cmd;
      finish_txn(9, rd);
      ok = f1 && f2;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (spi_wrt !== 1'b0) begin failures++; $display("FAIL reset_wrt got=%b exp=0", spi_wrt); end
      checks++; if (vld !== 1'b0 || vld_idx !== 2'd0) begin failures++; $display("FAIL reset_vld got=%b/%0d exp=0/0", vld, vld_idx); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (spi_cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd got=%h exp=0000", spi_cmd); end
      checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin failures++;
         $display("FAIL reset_regs got=%h exp=000000000000", {lft_ld, rght_ld, steer_pot, batt}); end
   endtask

   task automatic test_single();
      int t1, t2; logic [15:0] c1, c2; bit ok;
      pulse_nxt();
      checks++; if (spi_wrt !== 1'b1) begin failures++; $display("FAIL single_latency wrt got=%b exp=1", spi_wrt); end
      do_conv(16'h0ABC, t1, t2, c1, c2, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_wrt_seen got=0 exp=1"); end
      checks++; if (c1 !== 16'h0000 || c2 !== 16'h0000) begin failures++; $display("FAIL single_cmd got=%h/%h exp=0000/0000", c1, c2); end
      checks++; if (t2 - t1 !== 11) begin failures++; $display("FAIL single_wrt_gap got=%0d exp=11", t2 - t1); end
      checks++; if (vld !== 1'b1 || vld_idx !== 2'd0) begin failures++; $display("FAIL single_vld got=%b/%0d exp=1/0", vld, vld_idx); end
      checks++; if (lft_ld !== 12'hABC) begin failures++; $display("FAIL single_lft got=%h exp=abc", lft_ld); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
      step();
      checks++; if (vld !== 1'b0) begin failures++; $display("FAIL single_vld_pulse got=%b exp=0", vld); end
   endtask

   task automatic test_round_robin();
      logic [15:0] rds [4]  = '{16'hF123, 16'h0456, 16'h0789, 16'h0FFF};
      logic [15:0] cmds [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
      int t1, t2; logic [15:0] c1, c2; bit ok;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse_nxt();
         do_conv(rds[i], t1, t2, c1, c2, ok);
         checks++; if (!ok || c1 !== cmds[i] || c2 !== cmds[i]) begin failures++;
            $display("FAIL rr_cmd%0d got=%h/%h ok=%b exp=%h", i, c1, c2, ok, cmds[i]); end
         checks++; if (vld !== 1'b1 || vld_idx !== 2'(i)) begin failures++;
            $display("FAIL rr_vld%0d got=%b/%0d exp=1/%0d", i, vld, vld_idx, i); end
      end
      checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h123456789FFF) begin failures++;
         $display("FAIL rr_regs got=%h exp=123456789fff", {lft_ld, rght_ld, steer_pot, batt}); end
      pulse_nxt();
      do_conv(16'h0001, t1, t2, c1, c2, ok);
      checks++; if (!ok || c1 !== 16'h0000 || lft_ld !== 12'h001) begin failures++;
         $display("FAIL rr_wrap got=%h lft=%h exp=0000 lft=001", c1, lft_ld); end
   endtask

   task automatic test_back_to_back();
      int t1, t2, t3, t4, extra; bit f; logic [15:0] c1, c2;
      pulse_nxt();
      t1 = cyc;
      for (int k = 1; k <= 9; k++) begin
         step();
         nxt      = (k == 2 || k == 5 || k == 7);
         spi_done = (k == 9);
      end
      step();
      nxt = 1'b0; spi_done = 1'b0;
      wait_wrt(t2, f);
      checks++; if (!f || t2 - t1 !== 11) begin failures++; $display("FAIL b2b_tx2 got=%0d exp=11", t2 - t1); end
      repeat (9) step();
      spi_done = 1'b1; spi_rd = 16'h0321;
      step();
      spi_done = 1'b0; spi_rd = 16'h0000;
      checks++; if (busy !== 1'b0 || vld !== 1'b1) begin failures++; $display("FAIL b2b_idle got=busy%b vld%b exp=busy0 vld1", busy, vld); end
      step();
      checks++; if (spi_wrt !== 1'b1) begin failures++; $display("FAIL b2b_tx1_gap got=%b exp=1", spi_wrt); end
      do_conv(16'h0654, t3, t4, c1, c2, f);
      checks++; if (!f || t3 !== t2 + 11) begin failures++; $display("FAIL b2b_second got=%0d exp=%0d", t3, t2 + 11); end
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         if (spi_wrt) extra++;
         step();
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=0", extra); end
   endtask

   task automatic test_nxt_at_done();
      int t1, t2; bit f;
      pulse_nxt();
      wait_wrt(t1, f);
      finish_txn(9, 16'h0BAD);
      wait_wrt(t2, f);
      repeat (9) step();
      spi_done = 1'b1; nxt = 1'b1; spi_rd = 16'h0AAA;
      step();
      spi_done = 1'b0; nxt = 1'b0; spi_rd = 16'h0000;
      checks++; if (busy !== 1'b0 || vld !== 1'b1) begin failures++; $display("FAIL coinc_idle got=busy%b vld%b exp=busy0 vld1", busy, vld); end
      step();
      checks++; if (spi_wrt !== 1'b1) begin failures++; $display("FAIL coinc_tx1 got=%b exp=1", spi_wrt); end
      finish_txn(9, 16'h0BAD);
      wait_wrt(t2, f);
      finish_txn(9, 16'h0BBB);
   endtask

   task automatic test_timeout();
      int t1, t2; bit seen; bit f; logic [15:0] c1, c2;
      do_reset();
      pulse_nxt();
      seen = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (vld) seen = 1'b1;
         if (k == 16) begin
            checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++;
               $display("FAIL to_early got=err%b busy%b exp=err0 busy1", err, busy); end
         end
      end
      step();
      if (vld) seen = 1'b1;
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_err got=err%b busy%b exp=err1 busy0", err, busy); end
      checks++; if (seen !== 1'b0 || lft_ld !== 12'h000) begin failures++; $display("FAIL to_noupd got=vld%b lft=%h exp=vld0 lft=000", seen, lft_ld); end
      pulse_nxt();
      do_conv(16'h0456, t1, t2, c1, c2, f);
      checks++; if (!f || c1 !== 16'h2000) begin failures++; $display("FAIL to_next_idx got=%h exp=2000", c1); end
      checks++; if (rght_ld !== 12'h456 || vld_idx !== 2'd1 || err !== 1'b1) begin failures++;
         $display("FAIL to_after got=%h idx%0d err%b exp=456 idx1 err1", rght_ld, vld_idx, err); end
   endtask

   task automatic test_reset_mid();
      int t1, t2; bit f, seen;
      pulse_nxt();
      wait_wrt(t1, f);
      finish_txn(9, 16'h0BAD);
      wait_wrt(t2, f);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      seen = vld;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      spi_done = 1'b1; spi_rd = 16'h0FFF;
      step();
      spi_done = 1'b0; spi_rd = 16'h0000;
      if (vld) seen = 1'b1;
      step();
      if (vld) seen = 1'b1;
      checks++; if (seen !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin failures++;
         $display("FAIL rmid_stray got=vld%b busy%b err%b exp=000", seen, busy, err); end
      checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin failures++;
         $display("FAIL rmid_regs got=%h exp=000000000000", {lft_ld, rght_ld, steer_pot, batt}); end
      pulse_nxt();
      checks++; if (spi_wrt !== 1'b1 || spi_cmd !== 16'h0000) begin failures++;
         $display("FAIL rmid_next got=wrt%b cmd=%h exp=wrt1 cmd=0000", spi_wrt, spi_cmd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_nxt_at_done();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
